// File: rtl/vote_pkg.sv
// Shared state encodings and sizing helpers for the vote frame assembler.
package vote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } vote_st_e;

  localparam int N_VOTES_DEF = 7;
  localparam int IDX_W_DEF   = $clog2(N_VOTES_DEF);

  // Index width that never collapses to zero bits for tiny frames.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vote_gap_timer.sv
// Idle-gap watchdog for a partially filled frame; only built with VOTE_TIMEOUT_EN.
`ifdef VOTE_TIMEOUT_EN
module vote_gap_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic accept_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is the edge on which the gap count would reach TIMEOUT_CYC; an accept on that edge wins.
  assign expire_o = active_i & ~accept_i & (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!active_i || accept_i || expire_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/vote_frame_assembler.sv
// Serial vote collector feeding the 7-input majority stage over valid/ready.
// Optional idle-gap abort is enabled by defining VOTE_TIMEOUT_EN.
module vote_frame_assembler
  import vote_pkg::*;
#(
  parameter int N_VOTES     = N_VOTES_DEF,
  parameter int TIMEOUT_CYC = 16,
  parameter int FCNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vote_valid,
  input  logic               vote_bit,
  output logic               vote_ready,
  output logic               frame_valid,
  output logic [N_VOTES-1:0] frame_data,
  input  logic               frame_ready,
  output logic [FCNT_W-1:0]  frame_count,
  output logic               abort
);

  localparam int             IDX_W    = idx_w(N_VOTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOTES - 1);

  vote_st_e           state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N_VOTES-1:0] sh_q, sh_d, frame_data_q;
  logic               frame_valid_q;
  logic [FCNT_W-1:0]  fcnt_q;
  logic               accept, expire;

  assign vote_ready  = (state_q != ST_HOLD);
  assign accept      = vote_valid & vote_ready;
  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign frame_count = fcnt_q;

  always_comb begin
    sh_d = sh_q;
    if (accept) sh_d[idx_q] = vote_bit;
  end

`ifdef VOTE_TIMEOUT_EN
  logic abort_q;

  vote_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .active_i (state_q == ST_FILL),
    .accept_i (accept),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) abort_q <= 1'b0;
    else        abort_q <= expire;
  end

  assign abort = abort_q;
`else
  assign expire = 1'b0;
  assign abort  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      sh_q          <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      fcnt_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FILL: begin
          if (accept) begin
            if (idx_q == LAST_IDX) begin
              // Word is complete: publish it and clear the shifter for the next frame.
              state_q       <= ST_HOLD;
              frame_data_q  <= sh_d;
              frame_valid_q <= 1'b1;
              idx_q         <= '0;
              sh_q          <= '0;
            end else begin
              state_q <= ST_FILL;
              idx_q   <= idx_q + 1'b1;
              sh_q    <= sh_d;
            end
          end else if (expire) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sh_q    <= '0;
          end
        end
        ST_HOLD: begin
          if (frame_ready) begin
            state_q       <= ST_IDLE;
            frame_valid_q <= 1'b0;
            fcnt_q        <= fcnt_q + 1'b1;
            idx_q         <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
